// File: rtl/sram_controller_pkg.sv
// Shared CPU package: SRAM controller state encoding and memory-map constants.
package sram_controller_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LO,
    ST_HI,
    ST_WAIT,
    ST_DONE
  } sram_state_e;

  localparam logic [31:0] MEM_BASE_DEFAULT    = 32'd1024;
  localparam int unsigned WAIT_CYCLES_DEFAULT = 3;

endpackage

// File: rtl/sram_wait_counter.sv
// Loadable down-counter that times the idle-bus settle phase after an access.
module sram_wait_counter #(
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/sram_controller.sv
// MEM-stage SRAM controller: splits each 32-bit access into two 16-bit halves,
// then idles the bus for WAIT_CYCLES before signalling ready.
module sram_controller
  import sram_controller_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = sram_controller_pkg::WAIT_CYCLES_DEFAULT,
  parameter logic [31:0] MEM_BASE    = sram_controller_pkg::MEM_BASE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  inout  wire  [15:0] SRAM_DQ,
  output logic [17:0] SRAM_ADDR,
  output logic        SRAM_WE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N
);

  localparam int unsigned CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] WAIT_LOAD = CW'(WAIT_CYCLES - 1);

  sram_state_e state_q, state_d;
  logic        wr_q, wr_d;
  logic [31:0] rdata_q, rdata_d;
  logic        cnt_zero;

  logic [31:0] offset;
  logic [16:0] word;
  logic        unused_offset_bits;
  logic        dq_oe;
  logic [15:0] dq_out;

  assign offset             = address - MEM_BASE;
  assign word               = offset[18:2];
  assign unused_offset_bits = ^{offset[31:19], offset[1:0]};

  // Counter is loaded with WAIT_CYCLES-1 while in HI so WAIT spans WAIT_CYCLES cycles.
  sram_wait_counter #(
    .WIDTH (CW)
  ) u_wait (
    .clk        (clk),
    .rst        (rst),
    .load_i     (state_q == ST_HI),
    .load_val_i (WAIT_LOAD),
    .dec_i      (state_q == ST_WAIT),
    .zero_o     (cnt_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (wr_en || rd_en) begin
          state_d = ST_LO;
          wr_d    = wr_en;
        end
      end
      ST_LO:   state_d = ST_HI;
      ST_HI:   state_d = ST_WAIT;
      ST_WAIT: if (cnt_zero) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ready     = 1'b0;
    SRAM_WE_N = 1'b1;
    SRAM_ADDR = '0;
    dq_oe     = 1'b0;
    dq_out    = '0;
    unique case (state_q)
      ST_IDLE: ready = ~(wr_en | rd_en);
      ST_LO: begin
        SRAM_ADDR = {word, 1'b0};
        SRAM_WE_N = ~wr_q;
        dq_oe     = wr_q;
        dq_out    = write_data[15:0];
      end
      ST_HI: begin
        SRAM_ADDR = {word, 1'b1};
        SRAM_WE_N = ~wr_q;
        dq_oe     = wr_q;
        dq_out    = write_data[31:16];
      end
      ST_DONE: ready = 1'b1;
      default: ready = 1'b0;
    endcase
  end

  always_comb begin
    rdata_d = rdata_q;
    if (!wr_q && (state_q == ST_LO)) rdata_d[15:0]  = SRAM_DQ;
    if (!wr_q && (state_q == ST_HI)) rdata_d[31:16] = SRAM_DQ;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign read_data = rdata_q;
  assign SRAM_DQ   = dq_oe ? dq_out : 'z;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_OE_N = 1'b0;

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller with a small behavioural 16-bit SRAM model.
module tb_sram_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en, rd_en;
  logic [31:0] address, write_data;
  logic [31:0] read_data;
  logic        ready;
  wire  [15:0] sram_dq;
  logic [17:0] sram_addr;
  logic        sram_we_n, sram_ub_n, sram_lb_n, sram_ce_n, sram_oe_n;

  logic [15:0] mem [0:63];
  logic        mem_clr;

  int checks = 0;
  int errors = 0;

  logic [17:0] ob_addr_lo, ob_addr_hi;
  logic [15:0] ob_dq_lo, ob_dq_hi;
  logic        ob_we_lo, ob_we_hi, ob_ready0, ob_wait_bad, ob_ready_after;
  int          ob_ready_cyc;
  logic [31:0] ob_rdata;

  always #5 clk = ~clk;

  sram_controller dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .ready      (ready),
    .SRAM_DQ    (sram_dq),
    .SRAM_ADDR  (sram_addr),
    .SRAM_WE_N  (sram_we_n),
    .SRAM_UB_N  (sram_ub_n),
    .SRAM_LB_N  (sram_lb_n),
    .SRAM_CE_N  (sram_ce_n),
    .SRAM_OE_N  (sram_oe_n)
  );

  // SRAM model: drives the bus whenever the write strobe is inactive.
  assign sram_dq = sram_we_n ? mem[sram_addr[5:0]] : 'z;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 64; i++) mem[i] <= 16'hFFFF;
    end else if (!sram_we_n) begin
      mem[sram_addr[5:0]] <= sram_dq;
    end
  end

  // Drives one access from an aligned point (posedge+1 in IDLE, or in DONE when from_done)
  // and records what the bus did; comparisons live in the scenario tasks.
  task automatic run_access(input logic wr, input logic rd, input logic [31:0] a,
                            input logic [31:0] d, input bit from_done, input bit hold);
    wr_en = wr; rd_en = rd; address = a; write_data = d;
    if (from_done) begin
      @(posedge clk); #1;
    end else begin
      #1;
    end
    ob_ready0    = ready;
    ob_ready_cyc = -1;
    ob_wait_bad  = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin
        ob_addr_lo = sram_addr; ob_dq_lo = sram_dq; ob_we_lo = sram_we_n;
      end
      if (c == 2) begin
        ob_addr_hi = sram_addr; ob_dq_hi = sram_dq; ob_we_hi = sram_we_n;
      end
      if (c >= 3 && !sram_we_n) ob_wait_bad = 1'b1;
      if (ready) begin
        ob_ready_cyc = c;
        ob_rdata     = read_data;
        break;
      end
    end
    if (!hold) begin
      wr_en = 1'b0; rd_en = 1'b0;
      @(posedge clk); #1;
      ob_ready_after = ready;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; address = 32'd1024; write_data = '0;
    mem_clr = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    mem_clr = 1'b0;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", ready); end
    checks++; if (sram_we_n !== 1'b1) begin errors++; $display("FAIL reset_we_n: got %b expected 1", sram_we_n); end
    checks++; if (sram_addr !== 18'd0) begin errors++; $display("FAIL reset_addr: got %h expected 0", sram_addr); end
    checks++; if (read_data !== 32'd0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", read_data); end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b expected 1", ready); end
  endtask

  task automatic test_write();
    run_access(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 1'b0, 1'b0);
    checks++; if (ob_ready0 !== 1'b0) begin errors++; $display("FAIL wr_ready_c0: got %b expected 0", ob_ready0); end
    checks++; if (ob_addr_lo !== 18'd0) begin errors++; $display("FAIL wr_addr_lo: got %h expected 0", ob_addr_lo); end
    checks++; if (ob_dq_lo !== 16'hBEEF) begin errors++; $display("FAIL wr_dq_lo: got %h expected beef", ob_dq_lo); end
    checks++; if (ob_we_lo !== 1'b0) begin errors++; $display("FAIL wr_we_lo: got %b expected 0", ob_we_lo); end
    checks++; if (ob_addr_hi !== 18'd1) begin errors++; $display("FAIL wr_addr_hi: got %h expected 1", ob_addr_hi); end
    checks++; if (ob_dq_hi !== 16'hDEAD) begin errors++; $display("FAIL wr_dq_hi: got %h expected dead", ob_dq_hi); end
    checks++; if (ob_we_hi !== 1'b0) begin errors++; $display("FAIL wr_we_hi: got %b expected 0", ob_we_hi); end
    checks++; if (ob_ready_cyc !== 6) begin errors++; $display("FAIL wr_ready_cycle: got %0d expected 6", ob_ready_cyc); end
    checks++; if (ob_wait_bad !== 1'b0) begin errors++; $display("FAIL wr_we_in_wait: got %b expected 0", ob_wait_bad); end
    checks++; if (ob_ready_after !== 1'b1) begin errors++; $display("FAIL wr_ready_idle: got %b expected 1", ob_ready_after); end
    checks++; if ({mem[1], mem[0]} !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_mem: got %h expected deadbeef", {mem[1], mem[0]}); end
  endtask

  task automatic test_read();
    run_access(1'b0, 1'b1, 32'd1024, 32'h0, 1'b0, 1'b0);
    checks++; if (ob_we_lo !== 1'b1 || ob_we_hi !== 1'b1) begin errors++; $display("FAIL rd_we_n: got %b%b expected 11", ob_we_lo, ob_we_hi); end
    checks++; if (ob_dq_lo !== 16'hBEEF || ob_dq_hi !== 16'hDEAD) begin errors++; $display("FAIL rd_bus: got %h %h expected beef dead", ob_dq_lo, ob_dq_hi); end
    checks++; if (ob_ready_cyc !== 6) begin errors++; $display("FAIL rd_ready_cycle: got %0d expected 6", ob_ready_cyc); end
    checks++; if (ob_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data: got %h expected deadbeef", ob_rdata); end
  endtask

  task automatic test_back_to_back();
    run_access(1'b1, 1'b0, 32'd1028, 32'h12345678, 1'b0, 1'b0);
    checks++; if (ob_addr_lo !== 18'd2 || ob_addr_hi !== 18'd3) begin errors++; $display("FAIL b2b_wr_addr: got %h %h expected 2 3", ob_addr_lo, ob_addr_hi); end
    run_access(1'b0, 1'b1, 32'd1024, 32'h0, 1'b0, 1'b1);
    checks++; if (ob_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL b2b_rd0_data: got %h expected deadbeef", ob_rdata); end
    run_access(1'b0, 1'b1, 32'd1028, 32'h0, 1'b1, 1'b0);
    checks++; if (ob_ready0 !== 1'b0) begin errors++; $display("FAIL b2b_gap_ready: got %b expected 0", ob_ready0); end
    checks++; if (ob_addr_lo !== 18'd2 || ob_addr_hi !== 18'd3) begin errors++; $display("FAIL b2b_rd1_addr: got %h %h expected 2 3", ob_addr_lo, ob_addr_hi); end
    checks++; if (ob_ready_cyc !== 6) begin errors++; $display("FAIL b2b_rd1_cycle: got %0d expected 6", ob_ready_cyc); end
    checks++; if (ob_rdata !== 32'h12345678) begin errors++; $display("FAIL b2b_rd1_data: got %h expected 12345678", ob_rdata); end
  endtask

  task automatic test_simultaneous();
    run_access(1'b1, 1'b1, 32'd1032, 32'h0000A5A5, 1'b0, 1'b0);
    checks++; if (ob_we_lo !== 1'b0 || ob_we_hi !== 1'b0) begin errors++; $display("FAIL sim_we_n: got %b%b expected 00", ob_we_lo, ob_we_hi); end
    checks++; if (ob_addr_lo !== 18'd4 || ob_dq_lo !== 16'hA5A5) begin errors++; $display("FAIL sim_lo: got %h/%h expected 4/a5a5", ob_addr_lo, ob_dq_lo); end
    checks++; if ({mem[5], mem[4]} !== 32'h0000A5A5) begin errors++; $display("FAIL sim_mem: got %h expected 0000a5a5", {mem[5], mem[4]}); end
    checks++; if (read_data !== 32'h12345678) begin errors++; $display("FAIL sim_rdata_kept: got %h expected 12345678", read_data); end
  endtask

  task automatic test_reset_mid_write();
    wr_en = 1'b1; rd_en = 1'b0; address = 32'd1036; write_data = 32'h0BADF00D;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (sram_addr !== 18'd7 || sram_we_n !== 1'b0) begin errors++; $display("FAIL rstmid_in_hi: got %h/%b expected 7/0", sram_addr, sram_we_n); end
    rst = 1'b1;
    #1;
    checks++; if (sram_we_n !== 1'b1) begin errors++; $display("FAIL rstmid_we_n: got %b expected 1", sram_we_n); end
    checks++; if (sram_addr !== 18'd0) begin errors++; $display("FAIL rstmid_addr: got %h expected 0", sram_addr); end
    checks++; if (read_data !== 32'd0) begin errors++; $display("FAIL rstmid_rdata: got %h expected 0", read_data); end
    checks++; if (sram_dq !== 16'hBEEF) begin errors++; $display("FAIL rstmid_dq_released: got %h expected beef", sram_dq); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL rstmid_ready_req: got %b expected 0", ready); end
    wr_en = 1'b0;
    #1;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready_drop: got %b expected 1", ready); end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++; if (ready !== 1'b1 || sram_we_n !== 1'b1) begin errors++; $display("FAIL rstmid_no_resume: got ready=%b we_n=%b expected 1 1", ready, sram_we_n); end
    end
    checks++; if ({mem[7], mem[6]} !== 32'hFFFFF00D) begin errors++; $display("FAIL rstmid_mem: got %h expected fffff00d", {mem[7], mem[6]}); end
  endtask

  task automatic test_idle();
    address = 32'd1040; write_data = 32'hFFFF0000;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      checks++; if (ready !== 1'b1 || sram_we_n !== 1'b1 || sram_dq !== 16'hBEEF) begin
        errors++; $display("FAIL idle_cycle%0d: got ready=%b we_n=%b dq=%h expected 1 1 beef", i, ready, sram_we_n, sram_dq);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_simultaneous();
    test_reset_mid_write();
    test_idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
